// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and architectural register constants.
package mips_pkg;
  typedef logic [4:0]  reg_num_t;
  typedef logic [31:0] word_t;

  localparam reg_num_t REG_ZERO     = 5'd0;
  localparam reg_num_t REG_SP       = 5'd29;
  localparam reg_num_t REG_RA       = 5'd31;
  localparam word_t    SP_RESET_VAL = 32'd227;

  typedef struct packed {
    logic     en;
    reg_num_t num;
    word_t    data;
  } wr_port_t;

  // A write into $zero never lands, so it counts as no write at all.
  function automatic logic wr_eff(input wr_port_t wp);
    return wp.en && (wp.num != REG_ZERO);
  endfunction

  function automatic logic wr_hits(input wr_port_t wp, input reg_num_t rn);
    return wr_eff(wp) && (wp.num == rn);
  endfunction
endpackage

// File: rtl/operand_capture_reg.sv
// Operand latch (A or B) with load enable and optional same-edge write forwarding.
module operand_capture_reg
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  reg_num_t          rd_reg,
  input  logic [DATA_W-1:0] rd_val,
  input  wr_port_t          wr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] eff;

  always_comb begin
    eff = rd_val;
    if (BYPASS_EN && wr_hits(wr, rd_reg)) eff = wr.data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= eff;
  end
endmodule

// File: rtl/reg_bank_read_write.sv
// 32x32 MIPS register bank with combinational reads and registered A/B operands.
module reg_bank_read_write
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_RESET  = SP_RESET_VAL,
  parameter bit          BYPASS_EN = 1'b1,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              load_a,
  input  logic              load_b,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              wr_ack
);
  logic [DATA_W-1:0] regs [32];
  wr_port_t          wp;

  assign wp = '{en: reg_write, num: write_reg, data: write_data};

  // regs[0] is reset to zero and never written, so reads of $zero need no special case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
      wr_ack <= 1'b0;
    end else begin
      if (wr_eff(wp)) regs[write_reg] <= write_data;
      wr_ack <= wr_eff(wp);
    end
  end

  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];

  operand_capture_reg #(.DATA_W(DATA_W), .BYPASS_EN(BYPASS_EN)) u_cap_a (
    .clk(clk), .reset(reset), .load(load_a), .rd_reg(read_reg1),
    .rd_val(read_data1), .wr(wp), .q(a_out)
  );

  operand_capture_reg #(.DATA_W(DATA_W), .BYPASS_EN(BYPASS_EN)) u_cap_b (
    .clk(clk), .reset(reset), .load(load_b), .rd_reg(read_reg2),
    .rd_val(read_data2), .wr(wp), .q(b_out)
  );
endmodule

// File: tb/tb_reg_bank_read_write.sv
// Scoreboard bench: a bypassing and a non-bypassing bank driven by the same stimulus.
module tb_reg_bank_read_write;
  logic        clk = 1'b0, reset = 1'b1, reg_write = 1'b0, load_a = 1'b0, load_b = 1'b0;
  logic [4:0]  write_reg = '0, read_reg1 = '0, read_reg2 = '0;
  logic [31:0] write_data = '0;
  logic [31:0] rd1, rd2, a, b, nrd1, nrd2, na, nb;
  logic        ack, nack;

  reg_bank_read_write #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .load_a(load_a), .load_b(load_b), .read_data1(rd1), .read_data2(rd2),
    .a_out(a), .b_out(b), .wr_ack(ack)
  );

  reg_bank_read_write #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .load_a(load_a), .load_b(load_b), .read_data1(nrd1), .read_data2(nrd2),
    .a_out(na), .b_out(nb), .wr_ack(nack)
  );

  always #5 clk = ~clk;

  typedef enum {O_RD1, O_RD2, O_A, O_B, O_ACK, O_NA, O_NB} obs_e;
  typedef struct {
    obs_e        sel;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(input obs_e s);
    case (s)
      O_RD1:   return rd1;
      O_RD2:   return rd2;
      O_A:     return a;
      O_B:     return b;
      O_ACK:   return {31'b0, ack};
      O_NA:    return na;
      default: return nb;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input obs_e s, input string tag, input logic [31:0] e);
    exp_t x;
    x.sel = s; x.tag = tag; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, obs(x.sel), x.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    reg_write = 1'b1; write_reg = r; write_data = d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    push(O_A, "rst_a", 0); push(O_B, "rst_b", 0); push(O_ACK, "rst_ack", 0);
    settle();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      push(O_RD1, $sformatf("rst_rd%0d", i), (i == 29) ? 32'd227 : 32'd0);
      settle();
    end

    // plain write, one-cycle ack
    wr(5'd8, 32'hDEADBEEF); read_reg1 = 5'd8;
    push(O_RD1, "wr8_rd", 32'hDEADBEEF); push(O_ACK, "wr8_ack", 1);
    step();
    reg_write = 1'b0;
    push(O_ACK, "wr8_ack_off", 0);
    step();

    // write to $zero dropped
    wr(5'd0, 32'h12345678); read_reg1 = 5'd0;
    push(O_RD1, "wr0_rd", 0); push(O_ACK, "wr0_ack", 0);
    step();
    reg_write = 1'b0;

    // same-edge bypass on both ports
    wr(5'd9, 32'h55); read_reg1 = 5'd9; read_reg2 = 5'd9; load_a = 1'b1; load_b = 1'b1;
    push(O_A, "byp_a", 32'h55); push(O_B, "byp_b", 32'h55);
    push(O_NA, "nobyp_a", 0); push(O_NB, "nobyp_b", 0);
    step();
    reg_write = 1'b0;
    push(O_NA, "nobyp_a2", 32'h55); push(O_NB, "nobyp_b2", 32'h55); push(O_A, "byp_a2", 32'h55);
    step();

    // ports resolve bypass independently
    wr(5'd10, 32'hA); read_reg1 = 5'd10; read_reg2 = 5'd11;
    push(O_A, "ind_a", 32'hA); push(O_B, "ind_b", 0); push(O_NA, "ind_na", 0); push(O_NB, "ind_nb", 0);
    step();
    reg_write = 1'b0; load_a = 1'b0; load_b = 1'b0;

    // a_out holds while load_a is low
    for (int i = 0; i < 5; i++) begin
      wr(5'd10, 32'(100 + i));
      push(O_A, $sformatf("hold_a%0d", i), 32'hA);
      push(O_RD1, $sformatf("hold_rd%0d", i), 32'(100 + i));
      step();
    end
    reg_write = 1'b0;

    // full-width storage
    wr(5'd31, 32'hFFFFFFFF); read_reg2 = 5'd31;
    push(O_RD2, "wide_rd2", 32'hFFFFFFFF);
    step();
    reg_write = 1'b0;

    // $sp writable, then async reset mid-cycle
    wr(5'd29, 32'h100); read_reg1 = 5'd29;
    push(O_RD1, "sp_wr", 32'h100);
    step();
    reg_write = 1'b0; load_a = 1'b1;
    push(O_A, "sp_cap", 32'h100);
    step();
    load_a = 1'b0;
    #2;
    reset = 1'b1;
    push(O_RD1, "arst_sp", 32'd227); push(O_A, "arst_a", 0); push(O_B, "arst_b", 0);
    push(O_ACK, "arst_ack", 0); push(O_NA, "arst_na", 0);
    settle();
    wr(5'd29, 32'hFFFF); load_a = 1'b1; load_b = 1'b1;
    push(O_RD1, "inrst_sp", 32'd227); push(O_A, "inrst_a", 0); push(O_ACK, "inrst_ack", 0);
    step();
    reg_write = 1'b0; load_a = 1'b0; load_b = 1'b0; reset = 1'b0;
    read_reg1 = 5'd8;
    push(O_RD1, "post_rst_r8", 0);
    settle();
    read_reg1 = 5'd29;
    push(O_RD1, "post_rst_sp", 32'd227);
    settle();

    wr(5'd29, 32'h200);
    push(O_RD1, "sp_rewr", 32'h200); push(O_ACK, "sp_rewr_ack", 1);
    step();
    reg_write = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
